// File: rtl/shift_unit_if.sv
// Request/result bundle for shift_unit: master issues start/op/In/Amt, slave returns handshake and result.
interface shift_unit_if #(
    parameter int WIDTH = 32
);
    localparam int AW = $clog2(WIDTH);

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] In;
    logic [AW-1:0]    Amt;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Out;
    logic             Zero;

    modport master (
        output start, op, In, Amt,
        input  ready, busy, done, Out, Zero
    );

    modport slave (
        input  start, op, In, Amt,
        output ready, busy, done, Out, Zero
    );
endinterface

// File: rtl/shift_unit.sv
// shift_unit: multi-cycle SLL/SRL/SRA shifter moving at most STEP bit positions per cycle.
// Define SHIFT_UNIT_ROTATE_EN to make op=11 a rotate-left; otherwise op=11 behaves as SLL.
module shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input logic         clk,
    input logic         rst,
    shift_unit_if.slave bus
);
    localparam int AW = $clog2(WIDTH);
    localparam logic [AW:0] STEP_AMT = (AW + 1)'(STEP);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc;
    logic [AW-1:0]    rem;
    logic [1:0]       opr;
    logic             sgn;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             ready, busy, done;

    // Without the rotate option op=11 collapses to SLL at capture time.
    function automatic logic [1:0] decode_op(input logic [1:0] o);
`ifdef SHIFT_UNIT_ROTATE_EN
        decode_op = o;
`else
        decode_op = (o == OP_ROL) ? OP_SLL : o;
`endif
    endfunction

    function automatic logic [AW-1:0] step_amt(input logic [AW-1:0] r);
        if ({1'b0, r} < STEP_AMT)
            step_amt = r;
        else
            step_amt = STEP_AMT[AW-1:0];
    endfunction

    // SRA fills from the captured sign, not the current acc MSB.
    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] a,
                                                    input logic [1:0]       o,
                                                    input logic             s,
                                                    input logic [AW-1:0]    k);
        logic signed [WIDTH:0] ext;
        ext = {s, a};
        case (o)
            OP_SRL: shift_step = a >> k;
            OP_SRA: begin
                ext        = ext >>> k;
                shift_step = ext[WIDTH-1:0];
            end
`ifdef SHIFT_UNIT_ROTATE_EN
            OP_ROL: shift_step = (a << k) | (a >> (WIDTH - int'(k)));
`endif
            default: shift_step = a << k;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (bus.start)
                    state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (rem == '0)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            rem  <= '0;
            opr  <= OP_SLL;
            sgn  <= 1'b0;
            out  <= '0;
            zero <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        acc <= bus.In;
                        rem <= bus.Amt;
                        opr <= decode_op(bus.op);
                        sgn <= bus.In[WIDTH-1];
                    end
                end
                S_SHIFT: begin
                    if (rem != '0) begin
                        acc <= shift_step(acc, opr, sgn, step_amt(rem));
                        rem <= rem - step_amt(rem);
                    end else begin
                        out  <= acc;
                        zero <= (acc == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready = ready;
    assign bus.busy  = busy;
    assign bus.done  = done;
    assign bus.Out   = out;
    assign bus.Zero  = zero;
endmodule

// File: tb/tb_shift_unit.sv
// Randomised and directed bench for shift_unit (WIDTH=32, STEP=4) against a whole-amount shift model.
module tb_shift_unit;
    localparam int WIDTH = 32;
    localparam int STEP  = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   acc_cyc = 0;
    logic [31:0] last_out = '0;

    shift_unit_if #(.WIDTH(WIDTH)) bif ();

    shift_unit #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Whole-amount reference: one shift by the full Amt.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input int amt);
        logic [1:0]         o;
        logic signed [31:0] s;
        o = op;
`ifndef SHIFT_UNIT_ROTATE_EN
        if (o == 2'b11) o = 2'b00;
`endif
        s = a;
        case (o)
            2'b00:   return a << amt;
            2'b01:   return a >> amt;
            2'b10:   return s >>> amt;
            default: return (amt == 0) ? a : ((a << amt) | (a >> (32 - amt)));
        endcase
    endfunction

    function automatic int lat_of(input int amt);
        return (amt + STEP - 1) / STEP + 1;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic accept(input logic [1:0] o, input logic [31:0] a, input int amt);
        check("ready_before", 32'(bif.ready), 32'd1);
        check("out_held", bif.Out, last_out);
        bif.start = 1'b1;
        bif.op    = o;
        bif.In    = a;
        bif.Amt   = 5'(amt);
        @(posedge clk); #1;
        acc_cyc   = cyc;
        bif.start = 1'b0;
        bif.In    = $urandom;
        bif.Amt   = 5'($urandom);
        bif.op    = 2'($urandom);
        check("busy_after_accept", 32'(bif.busy), 32'd1);
    endtask

    task automatic finish(input string tag, input logic [31:0] exp_out, input int exp_lat, input bit poke);
        int n;
        n = 0;
        while (!bif.done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bif.done) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        check({tag, "_out"}, bif.Out, exp_out);
        check({tag, "_zero"}, 32'(bif.Zero), 32'(exp_out == 32'd0));
        check({tag, "_lat"}, 32'(cyc - acc_cyc), 32'(exp_lat));
        last_out = exp_out;
        if (poke) begin
            bif.start = 1'b1;
            bif.In    = ~exp_out;
            bif.Amt   = 5'd3;
        end
        @(posedge clk); #1;
        bif.start = 1'b0;
        check({tag, "_done_pulse"}, 32'(bif.done), 32'd0);
        check({tag, "_ready_after"}, 32'(bif.ready), 32'd1);
        check({tag, "_not_busy"}, 32'(bif.busy), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input int amt);
        accept(o, a, amt);
        finish(tag, model(o, a, amt), lat_of(amt), 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        bif.start = 1'b0;
        bif.op    = 2'b00;
        bif.In    = '0;
        bif.Amt   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bif.ready), 32'd1);
        check("rst_busy", 32'(bif.busy), 32'd0);
        check("rst_done", 32'(bif.done), 32'd0);
        check("rst_out", bif.Out, 32'd0);
        check("rst_zero", 32'(bif.Zero), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases from the datasheet examples.
        accept(2'b00, 32'h0000_0001, 2);
        finish("sll2", 32'h0000_0004, 2, 1'b1);
        run_op("sra31", 2'b10, 32'h8000_0000, 31);
        check("sra31_val", last_out, 32'hFFFF_FFFF);
        run_op("srl31", 2'b01, 32'h8000_0000, 31);
        check("srl31_val", last_out, 32'h0000_0001);
        run_op("sll_out0", 2'b00, 32'h8000_0000, 1);
        for (int o = 0; o < 4; o++)
            run_op("amt0", 2'(o), 32'hA5A5_1234, 0);

        // Start pulsed while busy must be ignored.
        accept(2'b01, 32'hF000_0000, 8);
        bif.start = 1'b1;
        bif.op    = 2'b00;
        bif.In    = 32'h1234_5678;
        bif.Amt   = 5'd1;
        @(posedge clk); #1;
        bif.start = 1'b0;
        finish("busy_ignore", 32'h00F0_0000, 3, 1'b0);

        // Reset mid-operation, with start asserted in the same cycle.
        accept(2'b00, 32'h0000_00FF, 20);
        repeat (2) begin
            @(posedge clk); #1;
            check("mid_no_done", 32'(bif.done), 32'd0);
        end
        rst       = 1'b1;
        bif.start = 1'b1;
        bif.In    = 32'h0000_0F00;
        bif.Amt   = 5'd3;
        @(posedge clk); #1;
        check("midrst_done", 32'(bif.done), 32'd0);
        check("midrst_out", bif.Out, 32'd0);
        check("midrst_zero", 32'(bif.Zero), 32'd1);
        check("midrst_ready", 32'(bif.ready), 32'd1);
        check("midrst_busy", 32'(bif.busy), 32'd0);
        rst       = 1'b0;
        bif.start = 1'b0;
        last_out  = '0;
        @(posedge clk); #1;
        check("postrst_busy", 32'(bif.busy), 32'd0);
        check("postrst_done", 32'(bif.done), 32'd0);

        run_op("op11", 2'b11, 32'h8000_0001, 4);
`ifdef SHIFT_UNIT_ROTATE_EN
        check("op11_val", last_out, 32'h0000_0018);
`else
        check("op11_val", last_out, 32'h0000_0010);
`endif

        // Random operations.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            run_op("rnd", 2'($urandom_range(0, 3)), a, $urandom_range(0, 31));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
